// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage fetch PC, credit-limited imem requests and fetch buffer feeding IF/ID.
// Define IF_PERF_CNT_EN to add perf_fetched_o / perf_dropped_o counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_dropped_o
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0] fetch_pc, rsp_pc, redirect_pc;
  logic [31:0] buf_pc [DEPTH];
  logic [31:0] buf_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic req_fire, rsp_fire, rsp_any, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign redirect_pc    = redirect_pc_i & ~32'd3;
  // Credit covers both in-flight and buffered words so responses never find the buffer full.
  assign imem_req_valid = rst_n && !redirect_i && drop_cnt == '0 &&
                          (SW'(outstanding) + SW'(count) < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && drop_cnt == '0 && outstanding != '0;
  assign rsp_any        = imem_rsp_valid && (drop_cnt != '0 || outstanding != '0);
  assign push           = rsp_fire && !redirect_i;
  assign fetch_valid_o  = count != '0;
  assign pop            = fetch_valid_o && !stall_i && !redirect_i;
  assign pc_o           = fetch_valid_o ? buf_pc[rd_ptr] : 32'h0;
  assign instruction_o  = fetch_valid_o ? buf_data[rd_ptr] : NOP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_i) begin
      fetch_pc    <= redirect_pc;
      rsp_pc      <= redirect_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + outstanding - CW'(rsp_any);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_fire) rsp_pc <= rsp_pc + 32'd4;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      drop_cnt    <= drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
    end
  always_ff @(posedge clk)
    if (push) begin
      buf_pc[wr_ptr]   <= rsp_pc;
      buf_data[wr_ptr] <= imem_rsp_data;
    end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetched_o <= '0;
      perf_dropped_o <= '0;
    end else begin
      perf_fetched_o <= perf_fetched_o + 32'(push);
      perf_dropped_o <= perf_dropped_o + (redirect_i ? 32'(count) : 32'h0) + 32'(rsp_any && !push);
    end
`endif
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && outstanding == '0 && drop_cnt == '0));
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus, queue-level reference model checked every cycle, literal pins.
module tb_if_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic stall, redirect;
  logic [31:0] redirect_pc;
  logic fetch_valid_o;
  logic [31:0] pc_o, instruction_o;
  int checks = 0, errors = 0;
  logic rsp_en = 1'b1;
  logic [31:0] pend[$], acc[$], q[$], infl[$];
  int drop = 0;
  logic [31:0] exp_pc = 32'h0;
  if_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .fetch_valid_o(fetch_valid_o), .pc_o(pc_o), .instruction_o(instruction_o)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Memory: answers each accepted request, in order, one cycle later (gated by rsp_en).
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    forever begin
      @(posedge clk);
      if (imem_rsp_valid && pend.size() > 0) pend.delete(0);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        acc.push_back(imem_req_addr);
      end
      #2;
      imem_rsp_valid = rsp_en && pend.size() > 0;
      imem_rsp_data = pend.size() > 0 ? f(pend[0]) : 32'h0;
    end
  end
  // Reference model: queues of kept in-flight PCs and presented PCs, plus a discard count.
  initial begin : model
    logic [31:0] p;
    logic pushq, rv;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        p = 32'h0;
        pushq = 1'b0;
        rv = !redirect && drop == 0 && infl.size() + q.size() < DEPTH;
        if (imem_rsp_valid) begin
          if (drop > 0) drop--;
          else if (infl.size() > 0) begin
            p = infl.pop_front();
            pushq = !redirect;
          end
        end
        if (!redirect && !stall && q.size() > 0) q.delete(0);
        if (pushq) q.push_back(p);
        if (rv && imem_req_ready) begin
          infl.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
        if (redirect) begin
          drop += infl.size();
          infl.delete();
          q.delete();
          exp_pc = redirect_pc & ~32'd3;
        end
      end
    end
  end
  initial begin : compare
    logic rv;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        rv = !redirect && drop == 0 && infl.size() + q.size() < DEPTH;
        chk("req_valid", 32'(imem_req_valid), 32'(rv));
        chk("req_addr", imem_req_addr, exp_pc);
        chk("fetch_valid", 32'(fetch_valid_o), 32'(q.size() != 0));
        chk("pc", pc_o, q.size() != 0 ? q[0] : 32'h0);
        chk("instruction", instruction_o, q.size() != 0 ? f(q[0]) : NOP);
      end
    end
  end
  task automatic wait_valid(input int n);
    for (int i = 0; i < n && !fetch_valid_o; i++) tick(1);
    chk("wait_valid", 32'(fetch_valid_o), 32'h1);
  endtask
  initial begin : driver
    logic [15:0] ps, pr;
    int k;
    imem_req_ready = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid_o), 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instruction", instruction_o, 32'h0000_0013);
    #11;
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    wait_valid(10);
    chk("t1_pc0", pc_o, 32'h0);
    chk("t1_ins0", instruction_o, 32'h0000_FFFF);
    tick(1);
    chk("t1_pc1", pc_o, 32'h4);
    chk("t1_ins1", instruction_o, 32'h0004_FFFB);
    tick(6);
    chk("t1_nreq", 32'(acc.size() >= 3), 32'h1);
    if (acc.size() >= 3) begin
      chk("t1_acc0", acc[0], 32'h0);
      chk("t1_acc1", acc[1], 32'h4);
      chk("t1_acc2", acc[2], 32'h8);
    end
    stall = 1'b1;
    tick(5);
    chk("t2_req_blocked", 32'(imem_req_valid), 32'h0);
    chk("t2_full_valid", 32'(fetch_valid_o), 32'h1);
    stall = 1'b0;
    tick(6);
    rsp_en = 1'b0;
    tick(6);
    chk("t3_credit", 32'(imem_req_valid), 32'h0);
    chk("t3_drained", 32'(fetch_valid_o), 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    tick(1);
    redirect = 1'b0;
    rsp_en = 1'b1;
    wait_valid(15);
    chk("t3_pc", pc_o, 32'h100);
    chk("t3_ins", instruction_o, 32'h0100_FEFF);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      #2;
      if (imem_rsp_valid) break;
    end
    chk("t4_rsp_seen", 32'(imem_rsp_valid), 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    wait_valid(15);
    chk("t4_pc", pc_o, 32'h200);
    tick(3);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick(1);
    redirect_pc = 32'h402;
    tick(1);
    redirect = 1'b0;
    wait_valid(15);
    chk("t5_pc", pc_o, 32'h400);
    imem_req_ready = 1'b0;
    tick(4);
    redirect = 1'b1;
    redirect_pc = 32'h500;
    tick(1);
    redirect = 1'b0;
    tick(3);
    chk("t6_valid_held", 32'(imem_req_valid), 32'h1);
    chk("t6_addr_held", imem_req_addr, 32'h500);
    imem_req_ready = 1'b1;
    tick(4);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    tick(10);
    k = -1;
    foreach (acc[i]) if (acc[i] == 32'hFFFF_FFFC) k = i;
    chk("t7_seen", 32'(k >= 0 && k + 1 < acc.size()), 32'h1);
    if (k >= 0 && k + 1 < acc.size()) chk("t7_wrap", acc[k+1], 32'h0);
    ps = 16'b0110_0011_1000_1101;
    pr = 16'b1011_1101_0110_1111;
    for (int i = 0; i < 16; i++) begin
      stall = ps[i];
      imem_req_ready = pr[i];
      tick(1);
    end
    stall = 1'b0;
    imem_req_ready = 1'b1;
    tick(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
